// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch controller: FSM encodings,
// the unconditional-jump opcode and instruction field positions.
package fetch_pkg;

    // FSM state encodings
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;  // issue request for pc_in
    localparam state_t S_WAIT = 2'd1;  // request outstanding
    localparam state_t S_HOLD = 2'd2;  // data parked in skid, IF/ID blocked
    localparam state_t S_KILL = 2'd3;  // draining a redirected request

    // PC-relative unconditional jump
    localparam logic [3:0] JMP_OPCODE = 4'hD;

    // Instruction field positions
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int OFF_HI = 11;
    localparam int OFF_LO = 0;

    // Sign-extend the 12-bit jump offset to a full word
    function automatic logic [15:0] sext_off(input logic [15:0] instr);
        return {{4{instr[OFF_HI]}}, instr[OFF_HI:OFF_LO]};
    endfunction

endpackage

// File: rtl/fetch_ctrl_jmp_target.sv
// Early jump decode: flags the PC-relative jump opcode and computes
// its target as pc + 1 + sext(offset), wrapping at 16 bits.
module jmp_target (
    input  logic [15:0] i_pc,
    input  logic [15:0] i_instr,
    output logic        o_is_jmp,
    output logic [15:0] o_target
);
    import fetch_pkg::*;

    assign o_is_jmp = (i_instr[OPC_HI:OPC_LO] == JMP_OPCODE);
    assign o_target = i_pc + 16'd1 + sext_off(i_instr);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller. Fetches the word at pc_in from a
// variable-latency memory, loads the IF/ID register (via a one-entry skid
// when decode is blocked) and drives stall/isBranch/branchAddr back to the
// PC register.
//
// Handshake: imem_req is held with a stable imem_addr until imem_ready
// pulses for one cycle; that pulse completes the request and qualifies
// imem_rdata. A request is never abandoned except by rst, so a redirect
// while waiting drains the request in KILL and drops its data.
module fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_in,
    output logic        stall,
    output logic        isBranch,
    output logic [15:0] branchAddr,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    input  logic        id_stall,
    input  logic        ex_redirect,
    input  logic [15:0] ex_target,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [1:0]  dbg_state
);
    import fetch_pkg::*;

    state_t      r_state;
    logic [15:0] r_req_addr;
    logic [15:0] r_skid;
    logic        r_if_valid;
    logic [15:0] r_if_instr;
    logic [15:0] r_if_pc;

    state_t      w_next;
    logic        w_free;
    logic        w_load;
    logic        w_skid_cap;
    logic [15:0] w_load_instr;
    logic        w_is_jmp;
    logic [15:0] w_target;

    // IF/ID can take a new word if empty or being consumed this cycle
    assign w_free       = !r_if_valid || !id_stall;
    // HOLD releases from the skid; every other load comes from memory
    assign w_load_instr = (r_state == S_HOLD) ? r_skid : imem_rdata;

    jmp_target u_jmp (
        .i_pc     (pc_in),
        .i_instr  (w_load_instr),
        .o_is_jmp (w_is_jmp),
        .o_target (w_target)
    );

    // Next-state, memory request and PC control decode
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_skid_cap = 1'b0;
        imem_req   = 1'b0;
        imem_addr  = (r_state == S_IDLE) ? pc_in : r_req_addr;
        stall      = 1'b1;
        isBranch   = 1'b0;
        branchAddr = 16'd0;
        if (rst) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!ex_redirect) begin
                        imem_req = 1'b1;
                        w_next   = S_WAIT;
                    end
                end
                S_WAIT: begin
                    imem_req = 1'b1;
                    if (ex_redirect) begin
                        w_next = imem_ready ? S_IDLE : S_KILL;
                    end else if (imem_ready && w_free) begin
                        w_load = 1'b1;
                        w_next = S_IDLE;
                    end else if (imem_ready) begin
                        w_skid_cap = 1'b1;
                        w_next     = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (ex_redirect) begin
                        w_next = S_IDLE;
                    end else if (!id_stall) begin
                        w_load = 1'b1;
                        w_next = S_IDLE;
                    end
                end
                S_KILL: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        w_next = S_IDLE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
            if (w_load) begin
                stall      = 1'b0;
                isBranch   = w_is_jmp;
                branchAddr = w_is_jmp ? w_target : 16'd0;
            end
            // execute redirect overrides any load or skid capture
            if (ex_redirect) begin
                w_load     = 1'b0;
                w_skid_cap = 1'b0;
                stall      = 1'b0;
                isBranch   = 1'b1;
                branchAddr = ex_target;
            end
        end
    end

    // State, request address latch and skid register
    always_ff @(posedge clk) begin
        r_state <= w_next;
        if (rst) begin
            r_req_addr <= 16'd0;
            r_skid     <= 16'd0;
        end else begin
            if (r_state == S_IDLE) begin
                r_req_addr <= pc_in;
            end
            if (w_skid_cap) begin
                r_skid <= imem_rdata;
            end
        end
    end

    // IF/ID register: redirect clears, load fills, consume empties
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_valid <= 1'b0;
            r_if_instr <= 16'd0;
            r_if_pc    <= 16'd0;
        end else if (ex_redirect) begin
            r_if_valid <= 1'b0;
        end else if (w_load) begin
            r_if_valid <= 1'b1;
            r_if_instr <= w_load_instr;
            r_if_pc    <= pc_in;
        end else if (!id_stall) begin
            r_if_valid <= 1'b0;
        end
    end

    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: each vector is one clock cycle of inputs
// with hand-computed outputs sampled at the falling edge of that cycle.
module tb_fetch_ctrl;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_KILL = 2'd3;

    typedef struct {
        logic        rst;
        logic [15:0] pc;
        logic        rdy;
        logic [15:0] rdata;
        logic        ids;
        logic        exr;
        logic [15:0] ext;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_stall;
        logic        e_br;
        logic [15:0] e_ba;
        logic        e_val;
        logic [15:0] e_instr;
        logic [15:0] e_ipc;
        logic [1:0]  e_st;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] pc_in;
    logic        stall;
    logic        isBranch;
    logic [15:0] branchAddr;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        id_stall;
    logic        ex_redirect;
    logic [15:0] ex_target;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    vec_t tbl[$];

    fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .stall       (stall),
        .isBranch    (isBranch),
        .branchAddr  (branchAddr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .id_stall    (id_stall),
        .ex_redirect (ex_redirect),
        .ex_target   (ex_target),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .dbg_state   (dbg_state)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(
        input logic r, input logic [15:0] pc, input logic rdy, input logic [15:0] rdata,
        input logic ids, input logic exr, input logic [15:0] ext,
        input logic e_req, input logic [15:0] e_addr, input logic e_stall,
        input logic e_br, input logic [15:0] e_ba, input logic e_val,
        input logic [15:0] e_instr, input logic [15:0] e_ipc, input logic [1:0] e_st);
        vec_t v;
        v.rst = r;  v.pc = pc;  v.rdy = rdy;  v.rdata = rdata;
        v.ids = ids;  v.exr = exr;  v.ext = ext;
        v.e_req = e_req;  v.e_addr = e_addr;  v.e_stall = e_stall;
        v.e_br = e_br;  v.e_ba = e_ba;  v.e_val = e_val;
        v.e_instr = e_instr;  v.e_ipc = e_ipc;  v.e_st = e_st;
        return v;
    endfunction

    task automatic chk(input string tag, input string what,
                       input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
        end
    endtask

    // drive one cycle, compare at the falling edge, advance past the rising edge
    task automatic run(input vec_t v, input string tag);
        rst         = v.rst;
        pc_in       = v.pc;
        imem_ready  = v.rdy;
        imem_rdata  = v.rdata;
        id_stall    = v.ids;
        ex_redirect = v.exr;
        ex_target   = v.ext;
        @(negedge clk);
        chk(tag, "imem_req", {15'd0, imem_req}, {15'd0, v.e_req});
        if (v.e_req) chk(tag, "imem_addr", imem_addr, v.e_addr);
        chk(tag, "stall", {15'd0, stall}, {15'd0, v.e_stall});
        chk(tag, "isBranch", {15'd0, isBranch}, {15'd0, v.e_br});
        if (v.e_br || v.rst) chk(tag, "branchAddr", branchAddr, v.e_ba);
        chk(tag, "if_valid", {15'd0, if_valid}, {15'd0, v.e_val});
        chk(tag, "if_instr", if_instr, v.e_instr);
        chk(tag, "if_pc", if_pc, v.e_ipc);
        chk(tag, "state", {14'd0, dbg_state}, {14'd0, v.e_st});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;  pc_in = 16'd0;  imem_ready = 1'b0;  imem_rdata = 16'd0;
        id_stall = 1'b0;  ex_redirect = 1'b0;  ex_target = 16'd0;
        @(posedge clk);
        #1;

        // reset, straight-line latency 1, JMP accept, back-pressure with JMP in skid
        //                r  pc      rdy rdata    ids exr ext      req addr     stl br ba       val instr    ipc      st
        tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, ST_IDLE));
        tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, ST_IDLE));
        tbl.push_back(mk(0, 16'h0000, 1, 16'h1111, 0, 0, 16'h0000, 1, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, ST_WAIT));
        tbl.push_back(mk(0, 16'h0001, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0001, 1, 0, 16'h0000, 1, 16'h1111, 16'h0000, ST_IDLE));
        tbl.push_back(mk(0, 16'h0001, 1, 16'h2222, 0, 0, 16'h0000, 1, 16'h0001, 0, 0, 16'h0000, 0, 16'h1111, 16'h0000, ST_WAIT));
        tbl.push_back(mk(0, 16'h0002, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0002, 1, 0, 16'h0000, 1, 16'h2222, 16'h0001, ST_IDLE));
        tbl.push_back(mk(0, 16'h0002, 1, 16'h3333, 0, 0, 16'h0000, 1, 16'h0002, 0, 0, 16'h0000, 0, 16'h2222, 16'h0001, ST_WAIT));
        tbl.push_back(mk(0, 16'h0010, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0010, 1, 0, 16'h0000, 1, 16'h3333, 16'h0002, ST_IDLE));
        tbl.push_back(mk(0, 16'h0010, 1, 16'hDFFE, 0, 0, 16'h0000, 1, 16'h0010, 0, 1, 16'h000F, 0, 16'h3333, 16'h0002, ST_WAIT));
        tbl.push_back(mk(0, 16'h000F, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h000F, 1, 0, 16'h0000, 1, 16'hDFFE, 16'h0010, ST_IDLE));
        tbl.push_back(mk(0, 16'h000F, 1, 16'hD003, 1, 0, 16'h0000, 1, 16'h000F, 1, 0, 16'h0000, 1, 16'hDFFE, 16'h0010, ST_WAIT));
        tbl.push_back(mk(0, 16'h000F, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'hDFFE, 16'h0010, ST_HOLD));
        tbl.push_back(mk(0, 16'h000F, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'hDFFE, 16'h0010, ST_HOLD));
        tbl.push_back(mk(0, 16'h000F, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'hDFFE, 16'h0010, ST_HOLD));
        tbl.push_back(mk(0, 16'h000F, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0013, 1, 16'hDFFE, 16'h0010, ST_HOLD));
        tbl.push_back(mk(0, 16'h0013, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0013, 1, 0, 16'h0000, 1, 16'hD003, 16'h000F, ST_IDLE));
        tbl.push_back(mk(0, 16'h0013, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0013, 1, 0, 16'h0000, 1, 16'hD003, 16'h000F, ST_WAIT));
        for (int i = 0; i < tbl.size(); i++) begin
            run(tbl[i], $sformatf("tbl%0d", i));
        end

        // redirect while waiting (latency 4): KILL drains, next request at target
        run(mk(0, 16'h0013, 0, 16'h0000, 1, 1, 16'h0200, 1, 16'h0013, 0, 1, 16'h0200, 1, 16'hD003, 16'h000F, ST_WAIT), "redir_wait");
        run(mk(0, 16'h0200, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0013, 1, 0, 16'h0000, 0, 16'hD003, 16'h000F, ST_KILL), "kill_1");
        run(mk(0, 16'h0200, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0013, 1, 0, 16'h0000, 0, 16'hD003, 16'h000F, ST_KILL), "kill_2");
        run(mk(0, 16'h0200, 1, 16'h5555, 0, 0, 16'h0000, 1, 16'h0013, 1, 0, 16'h0000, 0, 16'hD003, 16'h000F, ST_KILL), "kill_rdy");
        run(mk(0, 16'h0200, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0200, 1, 0, 16'h0000, 0, 16'hD003, 16'h000F, ST_IDLE), "after_kill");

        // redirect and JMP ready in the same cycle: redirect wins, nothing loaded
        run(mk(0, 16'h0200, 1, 16'hD005, 0, 1, 16'h0300, 1, 16'h0200, 0, 1, 16'h0300, 0, 16'hD003, 16'h000F, ST_WAIT), "redir_rdy");
        run(mk(0, 16'h0300, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0300, 1, 0, 16'h0000, 0, 16'hD003, 16'h000F, ST_IDLE), "after_rr");

        // reset in WAIT
        run(mk(1, 16'h0300, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'hD003, 16'h000F, ST_WAIT), "rst_wait");
        run(mk(0, 16'h0300, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0300, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, ST_IDLE), "post_rst1");

        // reset in HOLD
        run(mk(0, 16'h0300, 1, 16'h6666, 0, 0, 16'h0000, 1, 16'h0300, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, ST_WAIT), "fill");
        run(mk(0, 16'h0301, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0301, 1, 0, 16'h0000, 1, 16'h6666, 16'h0300, ST_IDLE), "blk_idle");
        run(mk(0, 16'h0301, 1, 16'h7777, 1, 0, 16'h0000, 1, 16'h0301, 1, 0, 16'h0000, 1, 16'h6666, 16'h0300, ST_WAIT), "blk_rdy");
        run(mk(1, 16'h0301, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h6666, 16'h0300, ST_HOLD), "rst_hold");
        run(mk(1, 16'h0301, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, ST_IDLE), "rst_held");

        // JMP at 16'hFFFF with zero offset wraps to 16'h0000
        run(mk(0, 16'hFFFF, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'hFFFF, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, ST_IDLE), "wrap_idle");
        run(mk(0, 16'hFFFF, 1, 16'hD000, 0, 0, 16'h0000, 1, 16'hFFFF, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, ST_WAIT), "wrap_jmp");
        run(mk(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 1, 0, 16'h0000, 1, 16'hD000, 16'hFFFF, ST_IDLE), "wrap_next");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
